rotmem_access_ctrl: RTL and testbench

//  Sequencer between a host and the bit-serial rotating byte store (one shift

---
 rtl/rotmem_access_ctrl.sv | 77 +++++++
 tb/tb_rotmem_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rotmem_access_ctrl.sv
// rotmem_access_ctrl: sequences host byte reads/writes onto a bit-serial rotating store,
// tracking the store's bit phase and word pointer in lockstep.
module rotmem_access_ctrl #(
    parameter int WORD_COUNT = 32,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              ack,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              mem_write,
    output logic              mem_din,
    input  logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] frame_ptr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W:0]   WC   = (ADDR_W + 1)'(WORD_COUNT);

    typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_R, XFER, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        phase;
    logic [ADDR_W-1:0] a_q, fp_inc, rd_target;
    logic [7:0]        d_q;
    logic              e_q, oor;

    assign fp_inc    = (frame_ptr == LAST) ? '0 : frame_ptr + 1'b1;
    assign rd_target = (a_q == LAST) ? '0 : a_q + 1'b1;
    assign oor       = {1'b0, addr} >= WC;
    assign ack       = state == DONE;
    assign err       = ack && e_q;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = oor ? DONE : (we ? WAIT_W : WAIT_R);
            WAIT_W:  if (phase == 3'd7 && fp_inc == a_q) state_nx = XFER;
            XFER:    if (phase == 3'd7) state_nx = DONE;
            WAIT_R:  if (phase == 3'd0 && frame_ptr == rd_target) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // serial drive is registered one cycle ahead so it is stable at the store's sampling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            frame_ptr <= '0;
            a_q       <= '0;
            d_q       <= '0;
            e_q       <= 1'b0;
            rdata     <= '0;
            mem_write <= 1'b0;
            mem_din   <= 1'b0;
        end else begin
            state     <= state_nx;
            phase     <= phase + 3'd1;
            frame_ptr <= (phase == 3'd7) ? fp_inc : frame_ptr;
            if (state == IDLE && req) begin
                a_q <= addr;
                d_q <= wdata;
                e_q <= oor;
            end
            if (state == WAIT_R && state_nx == DONE) rdata <= mem_dout;
            mem_write <= state_nx == XFER;
            mem_din   <= state_nx == XFER && d_q[3'(phase + 3'd1)];
        end
    end
endmodule

// File: tb/tb_rotmem_access_ctrl.sv
// tb_rotmem_access_ctrl: randomized and directed checks of the rotating-store sequencer
// against a cycle-count timeline model and a behavioural store.
module tb_rotmem_access_ctrl;
    localparam int W = 32;

    logic       clk = 0, reset = 1, req = 0, we = 0;
    logic [4:0] addr = 0;
    logic [7:0] wdata = 0;
    logic       ack, err, busy, mem_write, mem_din;
    logic [7:0] rdata, mem_dout;
    logic [4:0] frame_ptr;

    logic       req2 = 0;
    logic [4:0] addr2 = 0;
    logic       ack2, err2, busy2, mw2, md2;
    logic [7:0] rdata2;
    logic [4:0] fp2;
    bit         mw2_seen = 0;

    rotmem_access_ctrl #(.WORD_COUNT(W), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy), .mem_write(mem_write),
        .mem_din(mem_din), .mem_dout(mem_dout), .frame_ptr(frame_ptr));

    rotmem_access_ctrl #(.WORD_COUNT(24), .ADDR_W(5)) u24 (
        .clk(clk), .reset(reset), .req(req2), .we(1'b1), .addr(addr2), .wdata(8'hFF),
        .ack(ack2), .err(err2), .rdata(rdata2), .busy(busy2), .mem_write(mw2),
        .mem_din(md2), .mem_dout(8'h00), .frame_ptr(fp2));

    always #5 clk = ~clk;

    // behavioural rotating store: bit p of the slot word is replaced at phase p when writing
    logic [7:0] smem[W];
    logic [7:0] sw;
    logic [2:0] sph;
    logic [4:0] sptr;
    always_comb begin
        sw = smem[sptr];
        if (mem_write) sw[sph] = mem_din;
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sph <= 0; sptr <= 0; mem_dout <= 0;
        end else begin
            smem[sptr] <= sw;
            if (sph == 7) mem_dout <= sw;
            sph  <= sph + 3'd1;
            sptr <= (sph == 7) ? ((sptr == 5'(W - 1)) ? 5'd0 : sptr + 5'd1) : sptr;
        end
    end

    int cyc;
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
    always @(posedge clk) if (mw2) mw2_seen <= 1;

    int n_chk = 0, n_fail = 0;
    function automatic void chk(string nm, int got, int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, want, cyc);
        end
    endfunction

    // timeline model of the outstanding request
    bit         act = 0, m_wr = 0;
    int         t_acc = 0, ack_at = 0, xs = 0, m_ad = 0;
    logic [7:0] m_wd = 0, cur_rd = 0;
    logic [7:0] mmem[W];
    int         mw_first = -1, ack_seen = -1;
    logic [7:0] din_cap = 0;
    bit         e_mw, e_ack;

    always @(negedge clk) begin
        if (reset) cur_rd = 0;
        e_mw  = act && m_wr && cyc >= xs && cyc < xs + 8;
        e_ack = act && cyc == ack_at;
        if (e_ack && !m_wr) cur_rd = mmem[m_ad];
        if (e_ack && m_wr) mmem[m_ad] = m_wd;
        chk("frame_ptr", int'(frame_ptr), (cyc / 8) % W);
        chk("mem_write", int'(mem_write), int'(e_mw));
        chk("mem_din", int'(mem_din), e_mw ? int'(m_wd[cyc - xs]) : 0);
        chk("ack", int'(ack), int'(e_ack));
        chk("err", int'(err), 0);
        chk("busy", int'(busy), int'(act && cyc > t_acc && cyc <= ack_at));
        chk("rdata", int'(rdata), int'(cur_rd));
        if (mem_write && mw_first < 0) mw_first = cyc;
        if (mem_write && mw_first >= 0 && cyc - mw_first < 8) din_cap[cyc - mw_first] = mem_din;
        if (ack && ack_seen < 0) ack_seen = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input int a, input logic [7:0] d, input int gap);
        int s;
        while (act && cyc <= ack_at) step();
        repeat (gap) step();
        req = 1; we = w; addr = 5'(a); wdata = d;
        t_acc = cyc; m_wr = w; m_ad = a; m_wd = d;
        if (w) begin
            s = cyc + 2;
            while (s % 8 != 0 || (s / 8) % W != a) s++;
            xs = s; ack_at = s + 8;
        end else begin
            s = cyc + 1;
            while (s % 8 != 0 || (s / 8) % W != (a + 1) % W) s++;
            ack_at = s + 1;
        end
        mw_first = -1; ack_seen = -1; act = 1;
        step();
        req = 0; addr = 5'($urandom); wdata = 8'($urandom); we = 1'($urandom);
    endtask

    task automatic wait_done();
        while (cyc <= ack_at) step();
    endtask

    int ord[W];
    int t2, a, tmp, j;

    initial begin
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_frame_ptr", int'(frame_ptr), 0);
        reset = 0;

        issue(1, 3, 8'hA5, 0);
        wait_done();
        chk("w3_first_mw_cycle", mw_first, 24);
        chk("w3_din_bits", int'(din_cap), 'hA5);
        chk("w3_ack_cycle", ack_seen, 32);

        issue(0, 3, 8'h00, 0);
        wait_done();
        chk("r3_ack_cycle", ack_seen, 289);
        chk("r3_rdata", int'(rdata), 'hA5);

        for (int i = 0; i < W; i++) ord[i] = i;
        for (int i = W - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i)); tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < W; i++) issue(1, ord[i], 8'(ord[i] ^ 'h5A), int'($urandom_range(0, 5)));
        for (int i = W - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i)); tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < W; i++) begin
            issue(0, ord[i], 8'h00, int'($urandom_range(0, 5)));
            if (ord[i] == W - 1) begin
                wait_done();
                chk("r31_ack_frame", (ack_seen / 8) % W, 0);
                chk("r31_rdata", int'(rdata), 'h5A ^ 31);
            end
        end
        wait_done();

        while (cyc % 8 != 3) step();
        a = (cyc / 8) % W;
        issue(1, a, 8'($urandom), 0);
        wait_done();
        chk("late_write_start", mw_first - t_acc, 253);

        req2 = 1; addr2 = 5'd27; t2 = cyc;
        @(negedge clk);
        chk("e24_ack_early", int'(ack2), 0);
        step();
        req2 = 0;
        @(negedge clk);
        chk("e24_ack", int'(ack2), 1);
        chk("e24_err", int'(err2), 1);
        chk("e24_ack_delay", cyc - t2, 1);
        step();
        @(negedge clk);
        chk("e24_ack_drop", int'(ack2), 0);
        chk("e24_busy_drop", int'(busy2), 0);
        step();

        issue(1, 9, 8'h3C, 0);
        while (cyc != xs + 4) step();
        reset = 1; act = 0;
        #1;
        chk("rst_mid_mw", int'(mem_write), 0);
        chk("rst_mid_ack", int'(ack), 0);
        step(); step();
        reset = 0;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_frame_ptr", int'(frame_ptr), 0);
        issue(1, 5, 8'h96, 1);
        wait_done();
        issue(0, 5, 8'h00, 0);
        wait_done();
        chk("post_rst_rdata", int'(rdata), 'h96);
        chk("e24_never_mw", int'(mw2_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
